// File: rtl/alu_result_unpack.sv
// alu_result_unpack: splits one ALU result into per-thread register-file writes.
// Mode 1 sends the full result to thread A; mode 0 sends the low lane to A and
// the high lane to B. Each lane is held until its write port accepts it.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      result handshake (in_ready combinational from wb*_ready)
//   in_result, in_mode     XLEN result, 1 = full width, 0 = dual lane
//   in_rdA, in_rdB         destination registers for thread A / B
//   wbA_*, wbB_*           per-thread write request (valid/ready/rd/data)
//   busy                   at least one lane pending
//
// Option: define ALU_UNPACK_SEXT_EN to sign-extend mode-0 lanes (default zero-extend).

module alu_result_unpack #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_mode,
    input  logic [REG_AW-1:0] in_rdA,
    input  logic [REG_AW-1:0] in_rdB,
    output logic              wbA_valid,
    input  logic              wbA_ready,
    output logic [REG_AW-1:0] wbA_rd,
    output logic [XLEN-1:0]   wbA_data,
    output logic              wbB_valid,
    input  logic              wbB_ready,
    output logic [REG_AW-1:0] wbB_rd,
    output logic [XLEN-1:0]   wbB_data,
    output logic              busy
);

    localparam int LW = XLEN / 2;

    typedef enum logic [1:0] {
        EMPTY,
        A_ONLY,
        B_ONLY,
        BOTH
    } lane_state_e;

    lane_state_e state, state_nxt;

    logic              pend_a;
    logic              pend_b;
    logic              take;
    logic              new_a;
    logic              new_b;
    logic [XLEN-1:0]   lane_lo;
    logic [XLEN-1:0]   lane_hi;
    logic [REG_AW-1:0] a_rd_q;
    logic [REG_AW-1:0] b_rd_q;
    logic [XLEN-1:0]   a_data_q;
    logic [XLEN-1:0]   b_data_q;

    assign pend_a = (state == BOTH) || (state == A_ONLY);
    assign pend_b = (state == BOTH) || (state == B_ONLY);

`ifdef ALU_UNPACK_SEXT_EN
    assign lane_lo = {{LW{in_result[LW-1]}}, in_result[LW-1:0]};
    assign lane_hi = {{LW{in_result[XLEN-1]}}, in_result[XLEN-1:LW]};
`else
    assign lane_lo = {{LW{1'b0}}, in_result[LW-1:0]};
    assign lane_hi = {{LW{1'b0}}, in_result[XLEN-1:LW]};
`endif

    // Ready when every still-pending lane drains this cycle, so a new
    // entry can replace the old one without a bubble.
    always_comb begin
        in_ready  = (!pend_a || wbA_ready) && (!pend_b || wbB_ready);
        take      = in_valid && in_ready;
        new_a     = pend_a && !wbA_ready;
        new_b     = pend_b && !wbB_ready;
        state_nxt = state;
        if (take) begin
            // Register 0 is never written, so those lanes start out done.
            new_a = (in_rdA != '0);
            new_b = !in_mode && (in_rdB != '0);
        end
        unique case ({new_b, new_a})
            2'b11:   state_nxt = BOTH;
            2'b01:   state_nxt = A_ONLY;
            2'b10:   state_nxt = B_ONLY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            a_rd_q   <= '0;
            b_rd_q   <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                a_rd_q   <= in_rdA;
                b_rd_q   <= in_rdB;
                a_data_q <= in_mode ? in_result : lane_lo;
                b_data_q <= lane_hi;
            end
        end
    end

    assign wbA_valid = pend_a;
    assign wbB_valid = pend_b;
    assign wbA_rd    = a_rd_q;
    assign wbB_rd    = b_rd_q;
    assign wbA_data  = a_data_q;
    assign wbB_data  = b_data_q;
    assign busy      = pend_a || pend_b;

endmodule

// File: tb/tb_alu_result_unpack.sv
// tb_alu_result_unpack: directed vector table plus stall/reset sequences
// for alu_result_unpack.

module tb_alu_result_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_mode;
    logic [4:0]  in_rdA;
    logic [4:0]  in_rdB;
    logic        wbA_valid;
    logic        wbA_ready;
    logic [4:0]  wbA_rd;
    logic [63:0] wbA_data;
    logic        wbB_valid;
    logic        wbB_ready;
    logic [4:0]  wbB_rd;
    logic [63:0] wbB_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_unpack #(.XLEN(64), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_mode   (in_mode),
        .in_rdA    (in_rdA),
        .in_rdB    (in_rdB),
        .wbA_valid (wbA_valid),
        .wbA_ready (wbA_ready),
        .wbA_rd    (wbA_rd),
        .wbA_data  (wbA_data),
        .wbB_valid (wbB_valid),
        .wbB_ready (wbB_ready),
        .wbB_rd    (wbB_rd),
        .wbB_data  (wbB_data),
        .busy      (busy)
    );

    typedef struct {
        logic [63:0] result;
        logic        mode;
        logic [4:0]  rda;
        logic [4:0]  rdb;
        logic        a_v;
        logic [63:0] a_d;
        logic        b_v;
        logic [63:0] b_d;
    } vec_t;

    function automatic logic [63:0] ext32(input logic [31:0] v);
`ifdef ALU_UNPACK_SEXT_EN
        return {{32{v[31]}}, v};
`else
        return {32'h0, v};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    logic [63:0] held_b;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        in_mode   = 1'b0;
        in_rdA    = '0;
        in_rdB    = '0;
        wbA_ready = 1'b1;
        wbB_ready = 1'b1;

        vecs[0] = '{64'h1122334455667788, 1'b1, 5'd3, 5'd7,
                    1'b1, 64'h1122334455667788, 1'b0, 64'h0};
        vecs[1] = '{64'h800000017FFFFFFF, 1'b0, 5'd4, 5'd5,
                    1'b1, ext32(32'h7FFFFFFF), 1'b1, ext32(32'h80000001)};
        vecs[2] = '{64'hDEADBEEFCAFEF00D, 1'b0, 5'd0, 5'd0,
                    1'b0, 64'h0, 1'b0, 64'h0};
        vecs[3] = '{64'h00000005FFFFFFFF, 1'b0, 5'd0, 5'd9,
                    1'b0, 64'h0, 1'b1, ext32(32'h00000005)};
        vecs[4] = '{64'hFFFFFFFF80000000, 1'b0, 5'd31, 5'd0,
                    1'b1, ext32(32'h80000000), 1'b0, 64'h0};
        vecs[5] = '{64'h123456789ABCDEF0, 1'b0, 5'd1, 5'd2,
                    1'b1, ext32(32'h9ABCDEF0), 1'b1, ext32(32'h12345678)};
        vecs[6] = '{64'hA5A5A5A55A5A5A5A, 1'b1, 5'd0, 5'd6,
                    1'b0, 64'h0, 1'b0, 64'h0};
        vecs[7] = '{64'h0F0F0F0FF0F0F0F0, 1'b0, 5'd10, 5'd11,
                    1'b1, ext32(32'hF0F0F0F0), 1'b1, ext32(32'h0F0F0F0F)};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_a_valid", wbA_valid, 0);
        chk("rst_b_valid", wbB_valid, 0);
        chk("rst_busy",    busy,      0);
        chk("rst_ready",   in_ready,  1);
        chk("rst_a_data",  wbA_data,  0);
        chk("rst_b_rd",    wbB_rd,    0);

        // Back-to-back table with both ports always ready.
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_result = vecs[i].result;
            in_mode   = vecs[i].mode;
            in_rdA    = vecs[i].rda;
            in_rdB    = vecs[i].rdb;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("v%0d_a_valid", i), wbA_valid, vecs[i].a_v);
            chk($sformatf("v%0d_b_valid", i), wbB_valid, vecs[i].b_v);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].a_v | vecs[i].b_v);
            if (vecs[i].a_v) begin
                chk($sformatf("v%0d_a_rd", i), wbA_rd, vecs[i].rda);
                chk($sformatf("v%0d_a_data", i), wbA_data, vecs[i].a_d);
            end
            if (vecs[i].b_v) begin
                chk($sformatf("v%0d_b_rd", i), wbB_rd, vecs[i].rdb);
                chk($sformatf("v%0d_b_data", i), wbB_data, vecs[i].b_d);
            end
        end

        // Stream of 8 dual-lane results, one per cycle.
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_mode   = 1'b0;
            in_result = {32'h100 + 32'(i), 32'hF000_0000 + 32'(i)};
            in_rdA    = 5'(i + 1);
            in_rdB    = 5'(i + 17);
            #1;
            chk($sformatf("s%0d_in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("s%0d_a_data", i), wbA_data,
                ext32(32'hF000_0000 + 32'(i)));
            chk($sformatf("s%0d_b_data", i), wbB_data, 64'h100 + 64'(i));
            chk($sformatf("s%0d_b_rd", i), wbB_rd, 64'(i + 17));
            chk($sformatf("s%0d_valids", i), {wbA_valid, wbB_valid}, 2'b11);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_busy", busy, 0);

        // B lane stalled for 3 cycles while A drains.
        wbB_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_result = 64'h800000017FFFFFFF;
        in_rdA    = 5'd4;
        in_rdB    = 5'd5;
        tick();
        held_b    = ext32(32'h80000001);
        in_mode   = 1'b1;
        in_result = 64'hCAFEBABE00C0FFEE;
        in_rdA    = 5'd6;
        in_rdB    = 5'd0;
        chk("stall_c1_a_valid", wbA_valid, 1);
        chk("stall_c1_a_data", wbA_data, 64'h7FFFFFFF);
        chk("stall_c1_ready", in_ready, 0);
        for (int c = 2; c <= 3; c++) begin
            tick();
            chk($sformatf("stall_c%0d_a_valid", c), wbA_valid, 0);
            chk($sformatf("stall_c%0d_b_valid", c), wbB_valid, 1);
            chk($sformatf("stall_c%0d_b_data", c), wbB_data, held_b);
            chk($sformatf("stall_c%0d_b_rd", c), wbB_rd, 5);
            chk($sformatf("stall_c%0d_ready", c), in_ready, 0);
        end
        tick();
        chk("stall_c4_b_valid", wbB_valid, 1);
        chk("stall_c4_b_data", wbB_data, held_b);
        wbB_ready = 1'b1;
        #1;
        chk("stall_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("stall_next_a_valid", wbA_valid, 1);
        chk("stall_next_a_data", wbA_data, 64'hCAFEBABE00C0FFEE);
        chk("stall_next_a_rd", wbA_rd, 6);
        chk("stall_next_b_valid", wbB_valid, 0);
        tick();
        chk("stall_idle_busy", busy, 0);

        // Reset while both lanes pend.
        wbA_ready = 1'b0;
        wbB_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_result = 64'h1111111122222222;
        in_rdA    = 5'd7;
        in_rdB    = 5'd8;
        tick();
        in_valid = 1'b0;
        chk("both_busy", busy, 1);
        chk("both_valids", {wbA_valid, wbB_valid}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_a_valid", wbA_valid, 0);
        chk("rst2_b_valid", wbB_valid, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_ready", in_ready, 1);
        wbA_ready = 1'b1;
        wbB_ready = 1'b1;
        tick();
        chk("rst2_after_valids", {wbA_valid, wbB_valid}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
